fifo_push_arbiter: RTL
======================

# fifo_push_arbiter

Round-robin arbiter that shares the single push port of the team's `fifo` buffer between `NUM_REQ` producers. It sits directly in front of the FIFO's `push`/`data_in` inputs and sequences each write through the FIFO's multi-cycle push handshake. It watches the FIFO's `busy` and `full` outputs, and returns a one-cycle acknowledge to the producer whose word was stored.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 8: word width; must equal the FIFO `DATA_WIDTH`.
- `ID_WIDTH`, 2: width of the grant index; must satisfy 2^`ID_WIDTH` >= `NUM_REQ`.
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  `NUM_REQ`  per-producer write request, level.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  producer i word at bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `ack`  out  `NUM_REQ`  one-hot, one-cycle pulse: producer's word accepted by the FIFO.
- `grant_id`  out  `ID_WIDTH`  index of the producer currently being served; valid while `active`=1.
- `active`  out  1  high in every state except IDLE.
- `fifo_push`  out  1  drives FIFO `push`.
- `fifo_data`  out  `DATA_WIDTH`  drives FIFO `data_in`; registered.
- `fifo_busy`  in  1  FIFO `busy`.
- `fifo_full`  in  1  FIFO `full`.
- `word_count`  out  16  number of acknowledged words; wraps at 2^16.
- `retry_count`  out  8  number of failed push attempts; saturates at 255.

## Operation
- The FSM states are IDLE, ISSUE, CONFIRM, DRAIN and DONE.
- **IDLE**
  - If any `req` bit is set, `fifo_full`=0 and `fifo_busy`=0, the block grants one producer.
  - The winner is the first set `req` bit, searching upward from `last_ptr`+1 modulo `NUM_REQ`.
  - On grant, the block latches the winner's `req_data` into `fifo_data` and the winner's index into `grant_id`, then moves to ISSUE.
  - Otherwise the FSM stays in IDLE.
- **ISSUE**: `fifo_push`=1 for exactly one cycle, then the FSM moves to CONFIRM.
- **CONFIRM**
  - If `fifo_busy`=1, the FIFO took the push and the FSM moves to DRAIN.
  - If `fifo_busy`=0, the push was not taken. `retry_count` increments (saturating) and the FSM returns to ISSUE.
- **DRAIN**: stays while `fifo_busy`=1. When `fifo_busy`=0, the FSM moves to DONE.
- **DONE**
  - `ack[grant_id]`=1.
  - `word_count` increments.
  - `last_ptr` is set to `grant_id`.
  - The FSM moves to IDLE.
- `fifo_data` and `grant_id` stay constant from the grant until DONE inclusive. This meets the FIFO rule that `data_in` is held stable while `busy`=1.
- Producer contract:
  - Hold `req` high until `ack`.
  - Drop `req`, or present the next word, in the cycle after `ack`.
- Deasserting `req` after grant has no effect: the latched word is still written and acknowledged.
- `req_data` of non-granted producers is ignored.
- Reset values:
  - FSM in IDLE.
  - `fifo_push`=0, `ack`=0, `active`=0.
  - `fifo_data`=0, `grant_id`=0.
  - `last_ptr`=`NUM_REQ`-1, so producer 0 has first priority.
  - `word_count`=0, `retry_count`=0.

## Timing
- Nominal push sequence, with the grant in cycle T:
  - T: IDLE, grant.
  - T+1: ISSUE, `fifo_push`=1.
  - T+2: CONFIRM, `fifo_busy`=1.
  - T+3: DRAIN, `fifo_busy`=1.
  - T+4: DRAIN, `fifo_busy`=0.
  - T+5: DONE, `ack`=1.
  - T+6: IDLE, next grant possible.
- Request-to-ack latency is 5 cycles. Maximum throughput is 1 word per 6 cycles.
- With a simultaneous external pop, the FIFO uses the push-and-pop path with the same busy length, so the sequence is unchanged.
- `fifo_full`=1 blocks grants only in IDLE. Once granted, the transfer completes.
- If the FIFO is busy with an external pop in IDLE, the grant waits until `fifo_busy`=0.
- CONFIRM retries have no limit. Each retry adds 2 cycles.
- A reset asserted mid-transfer:
  - Takes effect immediately; the FSM returns to IDLE.
  - `fifo_push` drops and no `ack` is issued for the in-flight word.
  - The producer must re-request after reset.
- All outputs are registered, or decoded from the state register only. There is no combinational path from `req` to `fifo_push`.

## Test plan
- **Single request:** after reset, `req`=0001 with word 0xA5, FIFO model empty → `fifo_push` at T+1, `fifo_data`=0xA5, `ack`=0001 at T+5, `word_count`=1, FIFO holds 0xA5.
- **All producers contending:** `req`=1111 held continuously, words 0x10..0x13 → grant order 0,1,2,3,0; acks spaced 6 cycles apart; FIFO contents 0x10,0x11,0x12,0x13,0x10.
- **Full FIFO:** FIFO model at full, `req`=0100 → no `fifo_push` and `active`=0. After one external pop completes, grant `grant_id`=2 in the first IDLE cycle with `fifo_busy`=0.
- **Retry:** FIFO model ignores the first push (busy stays 0) → CONFIRM returns to ISSUE, `retry_count`=1, second push taken, `ack` 7 cycles after grant.
- **Reset mid-transfer:** `reset` pulsed in DRAIN → `active`=0, `fifo_push`=0, `ack`=0 immediately; `word_count`=0; next grant goes to producer 0 when its `req` is set.
- **Count wrap:** 65536 acknowledged words → `word_count` returns to 0.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing the FIFO push port between NUM_REQ producers.
// Each granted word goes through the FIFO push/busy handshake and is then acknowledged.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          active,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_busy,
  input  logic                          fifo_full,
  output logic [15:0]                   word_count,
  output logic [7:0]                    retry_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CONFIRM,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last_ptr;
  logic [ID_WIDTH-1:0] winner;
  logic                found;

  // First requester strictly after the most recently served producer, wrapping.
  always_comb begin
    winner = last_ptr;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[ID_WIDTH'((int'(last_ptr) + k) % NUM_REQ)]) begin
        winner = ID_WIDTH'((int'(last_ptr) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fifo_push   <= 1'b0;
      ack         <= '0;
      active      <= 1'b0;
      fifo_data   <= '0;
      grant_id    <= '0;
      last_ptr    <= ID_WIDTH'(NUM_REQ - 1);
      word_count  <= 16'd0;
      retry_count <= 8'd0;
    end else begin
      fifo_push <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (|req && !fifo_full && !fifo_busy) begin
            state     <= ISSUE;
            fifo_push <= 1'b1;
            active    <= 1'b1;
            grant_id  <= winner;
            fifo_data <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ISSUE: begin
          state <= CONFIRM;
        end
        // A push the FIFO did not take shows up as busy staying low.
        CONFIRM: begin
          if (fifo_busy) begin
            state <= DRAIN;
          end else begin
            state     <= ISSUE;
            fifo_push <= 1'b1;
            if (retry_count != 8'hFF) begin
              retry_count <= retry_count + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (!fifo_busy) begin
            state <= DONE;
            ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
          end
        end
        DONE: begin
          state      <= IDLE;
          active     <= 1'b0;
          word_count <= word_count + 16'd1;
          last_ptr   <= grant_id;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
